// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the byte-serialising memory arbiter: FSM states, access
// size codes, RAM byte width and the size-to-byte-count helper.
package riscv_mem_pkg;

  localparam int RAM_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MEM_SZ_B = 2'd0;
  localparam logic [1:0] MEM_SZ_H = 2'd1;
  localparam logic [1:0] MEM_SZ_W = 2'd2;
  localparam logic [1:0] MEM_SZ_D = 2'd3;

  // A dword request on a 32-bit port collapses to a word access.
  function automatic logic [3:0] size_bytes(input logic [1:0] size, input int data_w);
    logic [3:0] n;
    case (size)
      MEM_SZ_B: n = 4'd1;
      MEM_SZ_H: n = 4'd2;
      MEM_SZ_W: n = 4'd4;
      MEM_SZ_D: n = (data_w == 64) ? 4'd8 : 4'd4;
      default:  n = 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/byte_serdes.sv
// Beat counter plus byte serialiser (write) and little-endian assembler (read)
// for the memory arbiter.
module byte_serdes
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        cap_idx,
  input  logic [RAM_W-1:0]  din,
  output logic [3:0]        k,
  output logic [RAM_W-1:0]  tx_next,
  output logic [DATA_W-1:0] rx_next
);

  localparam int NB = DATA_W / RAM_W;

  logic [3:0]        k_r;
  logic [DATA_W-1:0] wbuf_r;
  logic [DATA_W-1:0] rx_r;

  // Next read word: cleared on a new grant, din dropped into its byte lane on capture.
  always_comb begin
    rx_next = rx_r;
    if (clr) begin
      rx_next = {DATA_W{1'b0}};
    end else if (cap_en) begin
      for (int i = 0; i < NB; i++) begin
        if (cap_idx == 3'(i)) begin
          rx_next[i*RAM_W +: RAM_W] = din;
        end else begin
          rx_next[i*RAM_W +: RAM_W] = rx_r[i*RAM_W +: RAM_W];
        end
      end
    end else begin
      rx_next = rx_r;
    end
  end

  // wbuf holds bytes k+1.. so the byte for the next beat is always in the low lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k_r    <= 4'd0;
      wbuf_r <= {DATA_W{1'b0}};
      rx_r   <= {DATA_W{1'b0}};
    end else begin
      rx_r <= rx_next;
      if (clr) begin
        k_r    <= 4'd0;
        wbuf_r <= wdata >> RAM_W;
      end else if (adv) begin
        k_r    <= k_r + 4'd1;
        wbuf_r <= {{RAM_W{1'b0}}, wbuf_r[DATA_W-1:RAM_W]};
      end
    end
  end

  assign k       = k_r;
  assign tx_next = wbuf_r[RAM_W-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide RAM between instruction fetch and the MEM-stage data port.
// Define IFETCH_BUF_EN to add a one-entry fetch buffer that short-cuts repeat fetches.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  input  logic [RAM_W-1:0]  ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [RAM_W-1:0]  ram_dout,
  output logic              ram_wr,
  output logic              busy
);

  logic [1:0]        state_r, state_nx;
  logic [ADDR_W-1:0] base_r;
  logic [3:0]        nbytes_r, nbytes_s, k_s;
  logic              we_r, own_mem_r, own_nx;
  logic              grant_mem_s, grant_if_s, hit_s, abort_s, last_beat_s;
  logic              clr_s, adv_s, cap_en_s;
  logic [2:0]        cap_idx_s;
  logic [RAM_W-1:0]  tx_next_s;
  logic [DATA_W-1:0] rx_next_s;
  logic [31:0]       buf_data_s;

  logic [ADDR_W-1:0] ram_addr_r, ram_addr_nx;
  logic [RAM_W-1:0]  ram_dout_r, ram_dout_nx;
  logic              ram_wr_r, ram_wr_nx, busy_r, busy_nx;
  logic              mem_valid_r, mem_valid_nx, if_valid_r, if_valid_nx;
  logic [DATA_W-1:0] mem_rdata_r, mem_rdata_nx;
  logic [31:0]       if_rdata_r, if_rdata_nx;

  byte_serdes #(.DATA_W(DATA_W)) u_serdes (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .adv     (adv_s),
    .cap_en  (cap_en_s),
    .wdata   (mem_wdata),
    .cap_idx (cap_idx_s),
    .din     (ram_din),
    .k       (k_s),
    .tx_next (tx_next_s),
    .rx_next (rx_next_s)
  );

  // Arbitration and next state; data wins ties and is never aborted by a flush.
  always_comb begin
    grant_mem_s = (state_r == ST_IDLE) && mem_req;
    grant_if_s  = (state_r == ST_IDLE) && !mem_req && if_req && !if_flush;
    nbytes_s    = grant_mem_s ? size_bytes(mem_size, DATA_W) : 4'd4;
    abort_s     = !own_mem_r && if_flush;
    last_beat_s = (k_s == (nbytes_r - 4'd1));
    own_nx      = (state_r == ST_IDLE) ? grant_mem_s : own_mem_r;
    clr_s       = grant_mem_s || grant_if_s;
    adv_s       = (state_r == ST_XFER);
    cap_en_s    = !we_r && (((state_r == ST_XFER) && (k_s != 4'd0)) || (state_r == ST_LAST));
    cap_idx_s   = (state_r == ST_LAST) ? 3'(nbytes_r - 4'd1) : 3'(k_s - 4'd1);
    state_nx    = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_mem_s) begin
          state_nx = ST_XFER;
        end else if (grant_if_s) begin
          state_nx = hit_s ? ST_DONE : ST_XFER;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (abort_s) begin
          state_nx = ST_IDLE;
        end else if (last_beat_s) begin
          state_nx = we_r ? ST_DONE : ST_LAST;
        end else begin
          state_nx = ST_XFER;
        end
      end
      ST_LAST: state_nx = abort_s ? ST_IDLE : ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, computed from the state being entered.
  always_comb begin
    ram_addr_nx = {ADDR_W{1'b0}};
    ram_dout_nx = {RAM_W{1'b0}};
    ram_wr_nx   = 1'b0;
    if (state_nx == ST_XFER) begin
      if (state_r == ST_IDLE) begin
        ram_addr_nx = grant_mem_s ? mem_addr : if_addr;
        ram_wr_nx   = grant_mem_s && mem_we;
        ram_dout_nx = (grant_mem_s && mem_we) ? mem_wdata[RAM_W-1:0] : {RAM_W{1'b0}};
      end else begin
        ram_addr_nx = base_r + ADDR_W'(k_s + 4'd1);
        ram_wr_nx   = we_r;
        ram_dout_nx = we_r ? tx_next_s : {RAM_W{1'b0}};
      end
    end else begin
      ram_addr_nx = {ADDR_W{1'b0}};
      ram_dout_nx = {RAM_W{1'b0}};
      ram_wr_nx   = 1'b0;
    end
    busy_nx      = (state_nx != ST_IDLE);
    mem_valid_nx = (state_nx == ST_DONE) && own_nx;
    if_valid_nx  = (state_nx == ST_DONE) && !own_nx;
    mem_rdata_nx = (mem_valid_nx && !we_r) ? rx_next_s : {DATA_W{1'b0}};
    if (if_valid_nx) begin
      if_rdata_nx = hit_s ? buf_data_s : rx_next_s[31:0];
    end else begin
      if_rdata_nx = 32'h0000_0000;
    end
  end

  // FSM, transfer context and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      base_r      <= {ADDR_W{1'b0}};
      nbytes_r    <= 4'd0;
      we_r        <= 1'b0;
      own_mem_r   <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_dout_r  <= {RAM_W{1'b0}};
      ram_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      mem_valid_r <= 1'b0;
      if_valid_r  <= 1'b0;
      mem_rdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nx;
      if (clr_s) begin
        base_r    <= grant_mem_s ? mem_addr : if_addr;
        nbytes_r  <= nbytes_s;
        we_r      <= grant_mem_s && mem_we;
        own_mem_r <= grant_mem_s;
      end
      ram_addr_r  <= ram_addr_nx;
      ram_dout_r  <= ram_dout_nx;
      ram_wr_r    <= ram_wr_nx;
      busy_r      <= busy_nx;
      mem_valid_r <= mem_valid_nx;
      if_valid_r  <= if_valid_nx;
      mem_rdata_r <= mem_rdata_nx;
      if_rdata_r  <= if_rdata_nx;
    end
  end

`ifdef IFETCH_BUF_EN
  logic [ADDR_W-3:0] buf_tag_r;
  logic              buf_vld_r;
  logic [31:0]       buf_data_r;

  function automatic logic wr_hits_tag(input logic [ADDR_W-1:0] addr, input logic [3:0] n,
                                       input logic [ADDR_W-3:0] tag);
    logic              hit;
    logic [ADDR_W-1:0] a;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a   = addr + ADDR_W'(i);
      hit = hit | ((4'(i) < n) && (a[ADDR_W-1:2] == tag));
    end
    return hit;
  endfunction

  // Only word-aligned fetches hit, so the stored word always starts at its tag.
  always_comb begin
    hit_s      = buf_vld_r && (if_addr[1:0] == 2'b00) && (if_addr[ADDR_W-1:2] == buf_tag_r);
    buf_data_s = buf_data_r;
  end

  // Fill on every completed fetch; drop on reset or an overlapping data write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_tag_r  <= {(ADDR_W-2){1'b0}};
      buf_vld_r  <= 1'b0;
      buf_data_r <= 32'h0000_0000;
    end else if ((state_r == ST_LAST) && (state_nx == ST_DONE) && !own_mem_r) begin
      buf_tag_r  <= base_r[ADDR_W-1:2];
      buf_vld_r  <= (base_r[1:0] == 2'b00);
      buf_data_r <= rx_next_s[31:0];
    end else if (grant_mem_s && mem_we && wr_hits_tag(mem_addr, nbytes_s, buf_tag_r)) begin
      buf_vld_r <= 1'b0;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign buf_data_s = 32'h0000_0000;
`endif

  assign ram_addr  = ram_addr_r;
  assign ram_dout  = ram_dout_r;
  assign ram_wr    = ram_wr_r;
  assign busy      = busy_r;
  assign mem_valid = mem_valid_r;
  assign mem_rdata = mem_rdata_r;
  // A flush seen during DONE still suppresses the fetch result.
  assign if_valid  = if_valid_r && !if_flush;
  assign if_rdata  = if_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1-cycle-latency byte RAM model.
module tb_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
`ifdef IFETCH_BUF_EN
  localparam int REFETCH_CYC = 1;
`else
  localparam int REFETCH_CYC = 6;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              mem_req, mem_we, mem_valid;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [7:0]        ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .busy(busy)
  );

  logic [7:0]        ram_q [0:(1<<ADDR_W)-1];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;

  always @(posedge clk) begin
    if (pl_en) ram_q[pl_addr] <= pl_data;
    else if (ram_wr) ram_q[ram_addr] <= ram_dout;
    ram_din <= ram_q[ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W-1:0] addr_log [0:31];
  logic [7:0]        dout_log [0:31];
  logic              wr_log   [0:31];
  logic              busy_log [0:31];
  int                n_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Starts at posedge+1 of the grant cycle (cycle 0); logs outputs per cycle.
  task automatic txn(input bit is_mem, input bit we, input logic [1:0] size,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input int flush_at, input int budget,
                     output int vcyc, output logic [31:0] rdata);
    vcyc = -1; rdata = 32'h0; n_wr = 0;
    for (int i = 0; i < 32; i++) begin
      addr_log[i] = '0; dout_log[i] = 8'h0; wr_log[i] = 1'b0; busy_log[i] = 1'b0;
    end
    for (int c = 0; c < budget && vcyc < 0; c++) begin
      if (c == 0) begin
        if (is_mem) begin
          mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        end else begin
          if_req = 1'b1; if_addr = addr;
        end
      end
      if_flush = (c == flush_at);
      if (flush_at >= 0 && c >= flush_at) if_req = 1'b0;
      @(negedge clk);
      addr_log[c] = ram_addr; dout_log[c] = ram_dout; wr_log[c] = ram_wr; busy_log[c] = busy;
      if (ram_wr) n_wr++;
      if (is_mem ? mem_valid : if_valid) begin
        vcyc  = c;
        rdata = is_mem ? mem_rdata : if_rdata;
      end
      @(posedge clk); #1;
    end
    mem_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
  endtask

  initial begin
    int vc, mv, iv;
    logic [31:0] rd, rd2;
    logic seen;
    rst = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 8'h0;
    @(posedge clk); #1;
    poke(17'h10, 8'h13); poke(17'h11, 8'h12); poke(17'h12, 8'h11); poke(17'h13, 8'h10);
    poke(17'h20, 8'hDE); poke(17'h21, 8'hAD); poke(17'h22, 8'hBE); poke(17'h23, 8'hEF);
    poke(17'h30, 8'h7F); poke(17'h31, 8'hFF);
    poke(17'h200, 8'h78); poke(17'h201, 8'h56); poke(17'h202, 8'h34); poke(17'h203, 8'h12);
    poke(17'h40, 8'h01); poke(17'h41, 8'h02); poke(17'h42, 8'h03); poke(17'h43, 8'h04);

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_addr", ram_addr, 17'h0);
    chk("rst_valids", {if_valid, mem_valid}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: word fetch
    txn(1'b0, 1'b0, 2'd2, 17'h10, 32'h0, -1, 16, vc, rd);
    chk("fetch_cyc", vc, 6);
    chk("fetch_data", rd, 32'h1011_1213);
    for (int i = 0; i < 4; i++) chk("fetch_addr", addr_log[i+1], 17'h10 + 17'(i));
    chk("fetch_no_wr", n_wr, 0);

    // 2: half write, then read back
    txn(1'b1, 1'b1, 2'd1, 17'h101, 32'h0000_BEEF, -1, 16, vc, rd);
    chk("wr_cyc", vc, 3);
    chk("wr_count", n_wr, 2);
    chk("wr_beat0", {wr_log[1], addr_log[1], dout_log[1]}, {1'b1, 17'h101, 8'hEF});
    chk("wr_beat1", {wr_log[2], addr_log[2], dout_log[2]}, {1'b1, 17'h102, 8'hBE});
    txn(1'b1, 1'b0, 2'd1, 17'h101, 32'h0, -1, 16, vc, rd);
    chk("rdh_cyc", vc, 4);
    chk("rdh_data", rd, 32'h0000_BEEF);

    // 3: simultaneous requests, data first
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 17'h30;
    if_req = 1'b1; if_addr = 17'h20;
    mv = -1; iv = -1; rd = 32'h0; rd2 = 32'h0;
    for (int c = 0; c < 20 && iv < 0; c++) begin
      @(negedge clk);
      if (mem_valid) begin mv = c; rd = mem_rdata; end
      if (if_valid) begin iv = c; rd2 = if_rdata; end
      @(posedge clk); #1;
      if (mv >= 0) mem_req = 1'b0;
    end
    if_req = 1'b0;
    chk("arb_mem_cyc", mv, 3);
    chk("arb_mem_data", rd, 32'h0000_007F);
    chk("arb_if_cyc", iv, 10);
    chk("arb_if_data", rd2, 32'hEFBE_ADDE);

    // 4: flush mid-fetch, then a new fetch
    txn(1'b0, 1'b0, 2'd2, 17'h80, 32'h0, 3, 10, vc, rd);
    chk("flush_no_valid", vc, -1);
    chk("flush_busy3", busy_log[3], 1'b1);
    chk("flush_busy4", busy_log[4], 1'b0);
    txn(1'b0, 1'b0, 2'd2, 17'h200, 32'h0, -1, 16, vc, rd);
    chk("post_flush_cyc", vc, 6);
    chk("post_flush_data", rd, 32'h1234_5678);

    // 5: reset during second byte of a word write
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 17'h300; mem_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk("rstx_beat1", {ram_wr, ram_addr, ram_dout}, {1'b1, 17'h301, 8'h33});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_outs", {ram_wr, ram_addr, ram_dout, busy, mem_valid, if_valid},
        {1'b0, 17'h0, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("rstx_rdata", {mem_rdata, if_rdata}, 64'h0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen = seen | mem_valid | busy;
    end
    chk("rstx_quiet", seen, 1'b0);
    @(posedge clk); #1;

    // 6: repeat fetch, invalidating write, refetch
    txn(1'b0, 1'b0, 2'd2, 17'h40, 32'h0, -1, 16, vc, rd);
    chk("buf_first_cyc", vc, 6);
    chk("buf_first_data", rd, 32'h0403_0201);
    txn(1'b0, 1'b0, 2'd2, 17'h40, 32'h0, -1, 16, vc, rd);
    chk("buf_second_cyc", vc, REFETCH_CYC);
    chk("buf_second_data", rd, 32'h0403_0201);
    chk("buf_second_addr", addr_log[1], (REFETCH_CYC == 1) ? 17'h0 : 17'h40);
    txn(1'b1, 1'b1, 2'd0, 17'h42, 32'h0000_00AA, -1, 16, vc, rd);
    chk("buf_wr_cyc", vc, 2);
    txn(1'b0, 1'b0, 2'd2, 17'h40, 32'h0, -1, 16, vc, rd);
    chk("buf_refetch_cyc", vc, 6);
    chk("buf_refetch_data", rd, 32'h04AA_0201);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised successor to the CPU's single-purpose byte-bus buffer. It arbitrates one byte-wide external RAM between the instruction-fetch port and the data (MEM stage) port. It serialises multi-byte reads and writes of 1/2/4/8 bytes, little-endian. Fetches can be aborted on a PC change. It sits between IF/MEM and the top-level RAM pins.

Parameters:
ADDR_W, 17, byte-address width of both ports and RAM.
DATA_W, 32, port data width; legal values 32 or 64.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
if_req  in  1  fetch request, level, held until if_valid or if_flush
if_addr  in  ADDR_W  fetch address, stable while if_req
if_flush  in  1  PC changed; abort fetch
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle pulse, if_rdata valid
mem_req  in  1  data request, level, held until mem_valid
mem_we  in  1  1=write, 0=read
mem_size  in  2  0=byte, 1=half, 2=word, 3=dword
mem_addr  in  ADDR_W  data byte address
mem_wdata  in  DATA_W  write data, low bytes used
mem_rdata  out  DATA_W  read data, zero-extended
mem_valid  out  1  one-cycle pulse, read data valid or write done
ram_din  in  8  byte returned by RAM
ram_addr  out  ADDR_W  RAM address
ram_dout  out  8  RAM write byte
ram_wr  out  1  1=write cycle
busy  out  1  state != IDLE

Behaviour:
- RAM read latency is 1 cycle: the address driven in cycle c returns its byte on ram_din in cycle c+1.
- Reset (rst=0 at a clk edge):
  - Go to IDLE, from any state, including mid-transfer.
  - All outputs 0 on the following cycle; ram_wr=0.
  - No valid pulse is issued for the aborted transfer.
- FSM states: IDLE, XFER, LAST, DONE.
- IDLE:
  - Samples requests. mem_req has priority over if_req.
  - On grant: latch base address, N bytes (fetch: 4; data: 1/2/4/8), direction, and wdata; clear counter k; go to XFER.
  - Outputs in IDLE: ram_addr=0, ram_wr=0, ram_dout=0.
- XFER:
  - Drive ram_addr = base+k (wrap modulo 2^ADDR_W).
  - Write: ram_dout = byte k of wdata, ram_wr=1.
  - Read: capture ram_din into byte k-1 when k>0.
  - k increments each cycle. After k=N-1: read goes to LAST, write goes to DONE.
- LAST: ram_wr=0; capture byte N-1; go to DONE.
- DONE:
  - Pulse the owning port's valid signal and present its data.
  - Requests are ignored; go to IDLE unconditionally.
- Latency, with the grant cycle counted as cycle 0:
  - Read of N bytes: valid in cycle N+2 (byte 3, half 4, word 6, dword 10).
  - Write of N bytes: done in cycle N+1.
  - Fetch: valid in cycle 6.
- mem_size=3 with DATA_W=32 is treated as a word access.
- Read data is zero-extended into mem_rdata/if_rdata; the unused upper bits are 0.
- if_flush:
  - During a fetch in XFER or LAST: go to IDLE at the next edge; no if_valid.
  - During a fetch in DONE: if_valid is suppressed.
  - if_flush in IDLE together with if_req: the fetch is not granted that cycle.
  - if_flush has no effect on data transfers.
- A data transfer is never aborted except by reset.
- The requester must deassert or replace its req on the edge after its valid pulse. The one-cycle IDLE after DONE prevents double acceptance.
- Simultaneous mem_req and if_req in IDLE: data is granted; the fetch waits for the next IDLE.

Optional Feature:
IFETCH_BUF_EN: one-entry fetch buffer holding a tag (word address), a valid bit, and 32-bit data.
- Filled on every completed fetch.
- An if_req in IDLE whose address hits the tag goes directly to DONE: if_valid in cycle 1, no RAM traffic.
- The entry is invalidated by reset and by any data write whose byte range overlaps the tagged word.
- mem_req keeps priority over a hit.
- When the macro is undefined, there is no buffer and every fetch takes 6 cycles.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - state encoding (IDLE/XFER/LAST/DONE)
  - size codes MEM_SZ_B/H/W/D
  - RAM_W=8
  - a size-to-byte-count function
- One natural sub-module, byte_serdes: beat counter plus byte shift/assemble register, parametrised by DATA_W.
- Arbitration and the FSM stay in mem_arbiter.

Test Plan:
1. Word fetch at 0x00010: RAM bytes 13 12 11 10 -> if_valid in cycle 6, if_rdata=0x10111213; ram_addr walks 0x10..0x13; ram_wr stays 0.
2. Data write of half 0xBEEF to 0x00101 -> ram_wr=1 for 2 cycles with (0x101,EF) then (0x102,BE); mem_valid in cycle 3.
3. mem_req and if_req asserted in the same IDLE cycle -> data read of byte 0x7F completes first (mem_valid in cycle 3, mem_rdata=0x0000007F); fetch is granted in the following IDLE.
4. if_flush asserted in cycle 3 of a fetch -> no if_valid; busy=0 in cycle 4; a new if_req at 0x200 completes 6 cycles after its grant.
5. rst=0 during the second byte of a word write -> ram_wr=0 next cycle, no mem_valid, all outputs 0.
6. With IFETCH_BUF_EN: fetch 0x40 twice -> second if_valid in cycle 1 with no RAM access. A byte write to 0x42, then a refetch of 0x40 -> full 6-cycle fetch returns the updated byte.
